deco_7seg_multiplex: RTL

- Time-multiplexed driver for N_DIGITS common-anode/cathode 7-segment digits sharing one segment bus.
- Takes a packed hex value plus decimal-point mask through a load handshake and scans digits at a fixed refresh rate.
- New data takes effect only at frame boundaries, so a frame never mixes old and new values.
- Adds leading-zero suppression and an anti-ghosting guard interval.
- Sits between the application logic and the board display pins.

---
 rtl/deco_7seg_pkg.sv | 33 +++
 rtl/deco_7seg_multiplex_hex_a_7seg.sv | 11 +
 rtl/deco_7seg_multiplex.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/deco_7seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Font patterns are stored active-low (0 = segment lit), bit6..bit0 = a..g.
package deco_7seg_pkg;

   localparam logic [6:0] FONT [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0001100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

   // All segments dark, active-low encoding.
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Converts an active-low pattern into the pin polarity of the board.
   function automatic logic [6:0] seg_polarity(input logic [6:0] seg_n,
                                               input logic       active_low);
      return active_low ? seg_n : ~seg_n;
   endfunction

endpackage

// File: rtl/deco_7seg_multiplex_hex_a_7seg.sv
// Hex nibble to active-low 7-segment pattern, purely combinational.
module hex_a_7seg
   import deco_7seg_pkg::*;
(
   input  logic [3:0] i_Nibble,
   output logic [6:0] o_Seg_N
);

   assign o_Seg_N = FONT[i_Nibble];

endmodule

// File: rtl/deco_7seg_multiplex.sv
// Time-multiplexed 7-segment driver. A prescaler slices time into digit
// slots; the digit index walks the slots. New data is held in a pending
// register and copied to the display register only at a frame boundary so a
// frame never mixes two values. Every pin is registered.
//
// Load handshake (valid/ready): i_Load is the valid. A transfer happens on a
// rising edge where i_Load=1 and o_Ready=1. o_Ready drops the next cycle and
// stays low while data is pending; i_Load while o_Ready=0 has no effect.
// o_Ready returns to 1 the cycle after the frame boundary that commits it.
module deco_7seg_multiplex
   import deco_7seg_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int GHOST_GUARD    = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
)(
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic [4*N_DIGITS-1:0] i_Value,
   input  logic [N_DIGITS-1:0]   i_Dp,
   input  logic                  i_Lz_En,
   input  logic                  i_Load,
   output logic                  o_Ready,
   output logic [6:0]            o_Segments,
   output logic                  o_Dp,
   output logic [N_DIGITS-1:0]   o_Anodes
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [N_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
   localparam logic                DP_OFF = SEG_ACTIVE_LOW;

   logic [PW-1:0]         r_Presc;
   logic [IW-1:0]         r_Idx;
   logic                  r_Pend_Valid;
   logic [4*N_DIGITS-1:0] r_Pend_Value;
   logic [N_DIGITS-1:0]   r_Pend_Dp;
   logic                  r_Pend_Lz;
   logic [4*N_DIGITS-1:0] r_Disp_Value;
   logic [N_DIGITS-1:0]   r_Disp_Dp;
   logic                  r_Disp_Lz;

   logic                  w_Tc;
   logic                  w_Boundary;
   logic [3:0]            w_Nibble;
   logic                  w_Dp_Sel;
   logic                  w_Blank_Sel;
   logic [N_DIGITS-1:0]   w_Onehot;
   logic [6:0]            w_Font_N;
   logic                  w_Lit;

   assign w_Tc       = (r_Presc == PW'(REFRESH_DIV - 1));
   assign w_Boundary = w_Tc && (r_Idx == IW'(N_DIGITS - 1));
   assign o_Ready    = ~r_Pend_Valid;

   // Prescaler and digit index: the index steps once per terminal count.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_Presc <= '0;
         r_Idx   <= '0;
      end else if (w_Tc) begin
         r_Presc <= '0;
         r_Idx   <= (r_Idx == IW'(N_DIGITS - 1)) ? '0 : r_Idx + IW'(1);
      end else begin
         r_Presc <= r_Presc + PW'(1);
      end
   end

   // Pending capture and frame-boundary commit. The two branches cannot both
   // apply, so a load accepted on a boundary waits for the next one.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_Pend_Valid <= 1'b0;
         r_Pend_Value <= '0;
         r_Pend_Dp    <= '0;
         r_Pend_Lz    <= 1'b0;
         r_Disp_Value <= '0;
         r_Disp_Dp    <= '0;
         r_Disp_Lz    <= 1'b0;
      end else if (r_Pend_Valid) begin
         if (w_Boundary) begin
            r_Disp_Value <= r_Pend_Value;
            r_Disp_Dp    <= r_Pend_Dp;
            r_Disp_Lz    <= r_Pend_Lz;
            r_Pend_Valid <= 1'b0;
         end
      end else if (i_Load) begin
         r_Pend_Value <= i_Value;
         r_Pend_Dp    <= i_Dp;
         r_Pend_Lz    <= i_Lz_En;
         r_Pend_Valid <= 1'b1;
      end
   end

   // Select the current digit's nibble, dp bit, blanking and anode bit.
   // Blanking walks from the most significant digit down while nibbles are 0.
   always_comb begin
      logic v_Zero_Run;
      w_Nibble    = 4'h0;
      w_Dp_Sel    = 1'b0;
      w_Blank_Sel = 1'b0;
      w_Onehot    = '0;
      v_Zero_Run  = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         v_Zero_Run = v_Zero_Run && (r_Disp_Value[4*k +: 4] == 4'h0);
         if (r_Idx == IW'(k)) begin
            w_Nibble    = r_Disp_Value[4*k +: 4];
            w_Dp_Sel    = r_Disp_Dp[k];
            w_Blank_Sel = r_Disp_Lz && v_Zero_Run && (k != 0);
            w_Onehot[k] = 1'b1;
         end
      end
   end

   hex_a_7seg u_hex_a_7seg (
      .i_Nibble (w_Nibble),
      .o_Seg_N  (w_Font_N)
   );

   assign w_Lit = (r_Presc >= PW'(GHOST_GUARD)) && !w_Blank_Sel;

   // Output pins: lit digit outside the guard interval, otherwise all dark.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Anodes   <= AN_OFF;
         o_Segments <= seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
         o_Dp       <= DP_OFF;
      end else if (w_Lit) begin
         o_Anodes   <= AN_ACTIVE_LOW ? ~w_Onehot : w_Onehot;
         o_Segments <= seg_polarity(w_Font_N, SEG_ACTIVE_LOW);
         o_Dp       <= SEG_ACTIVE_LOW ? ~w_Dp_Sel : w_Dp_Sel;
      end else begin
         o_Anodes   <= AN_OFF;
         o_Segments <= seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
         o_Dp       <= DP_OFF;
      end
   end

endmodule
